i2c_slave_write_rx: RTL and testbench



---
 rtl/i2c_slave_write_rx.sv | 192 +++++++++++++++++++
 tb/tb_i2c_slave_write_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_write_rx.sv
// I2C slave receiver for master writes: device address, register pointer, data.
// Each ACKed data byte becomes a single-cycle write strobe to a local regfile.
module i2c_slave_write_rx #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic       wrValid,
   output logic [7:0] wrAddr,
   output logic [7:0] wrData,
   output logic       busy,
   output logic       stopSeen
);

   typedef enum logic [2:0] {
      IDLE,
      RX_ADDR,
      ACK_ADDR,
      RX_REG,
      ACK_REG,
      RX_DATA,
      ACK_DATA,
      IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic       ack_q, ack_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       stop_q, stop_d;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall;
   logic start_c, stop_c;
   logic byte_done, rx_state, addr_hit;

   assign sda = ack_q ? 1'b0 : 1'bz;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign start_c  = scl_s & ~sda_s & sda_prev_q;
   assign stop_c   = scl_s & sda_s & ~sda_prev_q;

   assign byte_done = (cnt_q == 4'd8);
   assign rx_state  = (state_q == RX_ADDR) || (state_q == RX_REG) ||
                      (state_q == RX_DATA);
   assign addr_hit  = (shift_q[7:1] == SLAVE_ADDR) && !shift_q[0];

   assign wrValid  = wr_valid_q;
   assign wrAddr   = wr_addr_q;
   assign wrData   = wr_data_q;
   assign busy     = busy_q;
   assign stopSeen = stop_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      reg_addr_d = reg_addr_q;
      ack_d      = ack_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      stop_d     = 1'b0;

      if (stop_c) begin
         ack_d   = 1'b0;
         busy_d  = 1'b0;
         stop_d  = 1'b1;
         cnt_d   = 4'd0;
         state_d = IDLE;
      end else if (start_c) begin
         // busy is re-decided once the new address byte is complete
         ack_d   = 1'b0;
         cnt_d   = 4'd0;
         shift_d = 8'd0;
         state_d = RX_ADDR;
      end else begin
         if (rx_state && scl_rise && !byte_done) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
         end
         unique case (state_q)
            IDLE: ;
            IGNORE: ;
            RX_ADDR: begin
               if (byte_done) begin
                  if (!addr_hit) begin
                     busy_d  = 1'b0;
                     cnt_d   = 4'd0;
                     state_d = IGNORE;
                  end else if (scl_fall) begin
                     ack_d   = 1'b1;
                     busy_d  = 1'b1;
                     cnt_d   = 4'd0;
                     state_d = ACK_ADDR;
                  end
               end
            end
            ACK_ADDR: begin
               if (scl_fall) begin
                  ack_d   = 1'b0;
                  state_d = RX_REG;
               end
            end
            RX_REG: begin
               if (byte_done && scl_fall) begin
                  reg_addr_d = shift_q;
                  ack_d      = 1'b1;
                  cnt_d      = 4'd0;
                  state_d    = ACK_REG;
               end
            end
            ACK_REG: begin
               if (scl_fall) begin
                  ack_d   = 1'b0;
                  state_d = RX_DATA;
               end
            end
            RX_DATA: begin
               if (byte_done && scl_fall) begin
                  ack_d      = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = reg_addr_q;
                  wr_data_d  = shift_q;
                  cnt_d      = 4'd0;
                  state_d    = ACK_DATA;
               end
            end
            ACK_DATA: begin
               if (scl_fall) begin
                  ack_d      = 1'b0;
                  reg_addr_d = reg_addr_q + 8'd1;
                  state_d    = RX_DATA;
               end
            end
         endcase
      end
   end

   // synchronizers reset to the idle-bus level so release makes no edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         shift_q    <= 8'd0;
         reg_addr_q <= 8'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'd0;
         wr_data_q  <= 8'd0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         reg_addr_q <= reg_addr_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         stop_q     <= stop_d;
      end
   end

endmodule

// File: tb/tb_i2c_slave_write_rx.sv
// Directed bench for i2c_slave_write_rx: table of write transactions
// plus hand-built sequences for NACK, aborts, repeated START and reset.
module tb_i2c_slave_write_rx;

   localparam int H = 8;
   localparam int Q = 4;

   logic       clk;
   logic       rst;
   logic       scl;
   logic       m_low;
   wire        sda;
   logic       wrValid;
   logic [7:0] wrAddr;
   logic [7:0] wrData;
   logic       busy;
   logic       stopSeen;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_write_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda),
      .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData),
      .busy(busy), .stopSeen(stopSeen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0] mon_a[$];
   logic [7:0] mon_d[$];
   int         stop_cnt;
   bit         busy_seen;

   always @(negedge clk) begin
      if (wrValid) begin
         mon_a.push_back(wrAddr);
         mon_d.push_back(wrData);
      end
      if (stopSeen) stop_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   typedef struct {
      int         n;
      logic [7:0] b [5];
      logic [4:0] ack;
      int         nwr;
      logic [7:0] wa [2];
      logic [7:0] wd [2];
      bit         bsy;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mon_a.delete();
      mon_d.delete();
      stop_cnt  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic chk_wr(input string name, input int k,
                         input logic [7:0] ea, input logic [7:0] ed);
      chk({name, "_addr"}, (k < mon_a.size()) ? int'(mon_a[k]) : -1, ea);
      chk({name, "_data"}, (k < mon_d.size()) ? int'(mon_d[k]) : -1, ed);
   endtask

   task automatic start_c();
      clks(Q); m_low = 1'b0;
      clks(Q); scl = 1'b1;
      clks(H); m_low = 1'b1;
      clks(H); scl = 1'b0;
   endtask

   task automatic stop_c();
      clks(Q); m_low = 1'b1;
      clks(Q); scl = 1'b1;
      clks(H); m_low = 1'b0;
      clks(H);
   endtask

   task automatic send_bit(input logic b);
      clks(Q); m_low = ~b;
      clks(Q); scl = 1'b1;
      clks(H); scl = 1'b0;
   endtask

   task automatic ack_bit(output logic acked);
      clks(Q); m_low = 1'b0;
      clks(Q); scl = 1'b1;
      clks(H/2); acked = (sda == 1'b0);
      clks(H/2); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_bit(acked);
   endtask

   logic       a;
   logic [4:0] acks;

   initial begin
      rst = 1'b1; scl = 1'b1; m_low = 1'b0;
      clr_mon();

      tbl[0].n = 3; tbl[0].b = '{8'hA0, 8'h12, 8'hA5, 8'h00, 8'h00};
      tbl[0].ack = 5'b00111; tbl[0].nwr = 1; tbl[0].bsy = 1'b1;
      tbl[0].wa = '{8'h12, 8'h00}; tbl[0].wd = '{8'hA5, 8'h00};
      tbl[1].n = 3; tbl[1].b = '{8'hA2, 8'h12, 8'hA5, 8'h00, 8'h00};
      tbl[1].ack = 5'b00000; tbl[1].nwr = 0; tbl[1].bsy = 1'b0;
      tbl[1].wa = '{8'h00, 8'h00}; tbl[1].wd = '{8'h00, 8'h00};
      tbl[2].n = 4; tbl[2].b = '{8'hA0, 8'hFF, 8'h11, 8'h22, 8'h00};
      tbl[2].ack = 5'b01111; tbl[2].nwr = 2; tbl[2].bsy = 1'b1;
      tbl[2].wa = '{8'hFF, 8'h00}; tbl[2].wd = '{8'h11, 8'h22};
      tbl[3].n = 3; tbl[3].b = '{8'hA0, 8'h7E, 8'hC3, 8'h00, 8'h00};
      tbl[3].ack = 5'b00111; tbl[3].nwr = 1; tbl[3].bsy = 1'b1;
      tbl[3].wa = '{8'h7E, 8'h00}; tbl[3].wd = '{8'hC3, 8'h00};

      clks(3);
      chk("rst_wrValid", wrValid, 0);
      chk("rst_wrAddr", wrAddr, 0);
      chk("rst_wrData", wrData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stopSeen", stopSeen, 0);
      chk("rst_sda", sda, 1);
      rst = 1'b0;
      clks(5);

      for (int v = 0; v < 4; v++) begin
         clr_mon();
         acks = '0;
         start_c();
         for (int i = 0; i < tbl[v].n; i++) begin
            send_byte(tbl[v].b[i], a);
            acks[i] = a;
         end
         stop_c();
         clks(H);
         chk($sformatf("v%0d_acks", v), acks, tbl[v].ack);
         chk($sformatf("v%0d_nwr", v), mon_a.size(), tbl[v].nwr);
         for (int k = 0; k < tbl[v].nwr; k++)
            chk_wr($sformatf("v%0d_wr%0d", v, k), k, tbl[v].wa[k], tbl[v].wd[k]);
         chk($sformatf("v%0d_stop", v), stop_cnt, 1);
         chk($sformatf("v%0d_busy_end", v), busy, 0);
         chk($sformatf("v%0d_busy_seen", v), busy_seen, tbl[v].bsy);
      end

      // read address is NACKed, traffic ignored, repeated START recovers
      clr_mon();
      start_c();
      send_byte(8'hA1, a); chk("rd_addr_nack", a, 0);
      send_byte(8'h55, a); chk("rd_ignore_nack", a, 0);
      chk("rd_busy", busy, 0);
      start_c();
      send_byte(8'hA0, a); chk("rs_addr_ack", a, 1);
      send_byte(8'h20, a); chk("rs_reg_ack", a, 1);
      send_byte(8'h77, a); chk("rs_data_ack", a, 1);
      stop_c();
      clks(H);
      chk("rs_nwr", mon_a.size(), 1);
      chk_wr("rs_wr", 0, 8'h20, 8'h77);

      // partial data byte aborted by STOP
      clr_mon();
      start_c();
      send_byte(8'hA0, a);
      send_byte(8'h05, a);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      stop_c();
      clks(H);
      chk("part_nwr", mon_a.size(), 0);
      chk("part_stop", stop_cnt, 1);
      chk("part_busy", busy, 0);
      clr_mon();
      start_c();
      send_byte(8'hA0, a); chk("post_addr_ack", a, 1);
      send_byte(8'h06, a);
      send_byte(8'h3C, a);
      stop_c();
      clks(H);
      chk("post_nwr", mon_a.size(), 1);
      chk_wr("post_wr", 0, 8'h06, 8'h3C);

      // repeated START in the middle of a data byte
      clr_mon();
      start_c();
      send_byte(8'hA0, a);
      send_byte(8'h40, a);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      start_c();
      send_byte(8'hA0, a); chk("mid_rs_ack", a, 1);
      chk("mid_rs_busy", busy, 1);
      send_byte(8'h41, a);
      send_byte(8'h99, a);
      stop_c();
      clks(H);
      chk("mid_rs_nwr", mon_a.size(), 1);
      chk_wr("mid_rs_wr", 0, 8'h41, 8'h99);

      // reset while the slave holds sda low in a data ACK slot
      clr_mon();
      start_c();
      send_byte(8'hA0, a);
      send_byte(8'h10, a);
      for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b0 : 1'b1);
      clks(Q); m_low = 1'b0;
      clks(Q); scl = 1'b1;
      clks(H/2);
      chk("ack_hold_sda", sda, 0);
      chk("ack_hold_nwr", mon_a.size(), 1);
      chk_wr("ack_hold_wr", 0, 8'h10, 8'h55);
      #2 rst = 1'b1;
      #1;
      chk("arst_sda", sda, 1);
      chk("arst_wrValid", wrValid, 0);
      chk("arst_wrAddr", wrAddr, 0);
      chk("arst_wrData", wrData, 0);
      chk("arst_busy", busy, 0);
      chk("arst_stopSeen", stopSeen, 0);
      clks(4);
      rst = 1'b0;
      clks(5);

      clr_mon();
      start_c();
      send_byte(8'hA0, a); chk("after_rst_ack", a, 1);
      send_byte(8'h01, a);
      send_byte(8'hEE, a);
      stop_c();
      clks(H);
      chk("after_rst_nwr", mon_a.size(), 1);
      chk_wr("after_rst_wr", 0, 8'h01, 8'hEE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
